// File: rtl/mult_pipe_hs_if.sv
// Handshake bundle for mult_pipe_hs.
//   Input side : IN_VALID, IN_READY, A, B, TC (0 = unsigned, 1 = two's complement)
//   Output side: OUT_VALID, OUT_READY, PRODUCT (A_width+B_width bits)
// master = producer/consumer environment, slave = the multiplier.
interface mult_pipe_hs_if #(
  parameter int A_width = 8,
  parameter int B_width = 8
);
  logic                       IN_VALID;
  logic                       IN_READY;
  logic [A_width-1:0]         A;
  logic [B_width-1:0]         B;
  logic                       TC;
  logic                       OUT_VALID;
  logic                       OUT_READY;
  logic [A_width+B_width-1:0] PRODUCT;

  modport master (
    output IN_VALID, A, B, TC, OUT_READY,
    input  IN_READY, OUT_VALID, PRODUCT
  );

  modport slave (
    input  IN_VALID, A, B, TC, OUT_READY,
    output IN_READY, OUT_VALID, PRODUCT
  );
endinterface

// File: rtl/mult_pipe_hs.sv
// Pipelined A*B multiplier with valid/ready flow control.
//   CLK   : clock, rising edge
//   rst_n : async active-low reset, clears valid bits and all data registers
//   CLR   : synchronous flush of every in-flight operation (valid bits only)
//   bus   : slave side of mult_pipe_hs_if (A/B/TC in, full-width PRODUCT out)
// The product is formed at acceptance and then carried through num_stages
// registers; the last register drives PRODUCT/OUT_VALID. The whole pipe
// advances together when the output slot is empty or being consumed.

// One pipeline register with its valid bit. Data only loads for a valid
// incoming entry, so a bubble leaves the previous contents in place.
module mult_pipe_stage #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  input  logic         vld_in,
  input  logic [W-1:0] dat_in,
  output logic         vld_out,
  output logic [W-1:0] dat_out
);
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      dat_out <= '0;
    end else if (clr) begin
      vld_out <= 1'b0;
    end else if (adv) begin
      vld_out <= vld_in;
      if (vld_in) dat_out <= dat_in;
    end
  end
endmodule

module mult_pipe_hs #(
  parameter int A_width    = 8,
  parameter int B_width    = 8,
  parameter int num_stages = 4
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           CLR,
  mult_pipe_hs_if.slave  bus
);
  localparam int W = A_width + B_width;

  logic                            adv;
  logic                            acc;
  logic [W-1:0]                    a_ext;
  logic [W-1:0]                    b_ext;
  logic [W-1:0]                    prod_in;
  logic [num_stages-1:0]           vld_pipe;
  logic [num_stages-1:0][W-1:0]    prod_pipe;
  logic [num_stages-1:0]           stg_vld_in;
  logic [num_stages-1:0][W-1:0]    stg_dat_in;

  // Global stall: everything holds while a result waits at the output.
  assign adv          = !vld_pipe[num_stages-1] || bus.OUT_READY;
  assign bus.IN_READY = adv && !CLR;
  assign acc          = bus.IN_VALID && bus.IN_READY;

  // Extend both operands to the full product width (sign-extend only in TC
  // mode); the low W bits of the W x W product are then exact in both modes.
  assign a_ext   = {{B_width{bus.TC & bus.A[A_width-1]}}, bus.A};
  assign b_ext   = {{A_width{bus.TC & bus.B[B_width-1]}}, bus.B};
  assign prod_in = a_ext * b_ext;

  assign stg_vld_in[0] = acc;
  assign stg_dat_in[0] = prod_in;

  for (genvar g = 1; g < num_stages; g++) begin : g_link
    assign stg_vld_in[g] = vld_pipe[g-1];
    assign stg_dat_in[g] = prod_pipe[g-1];
  end

  for (genvar g = 0; g < num_stages; g++) begin : g_stg
    mult_pipe_stage #(.W(W)) u_stg (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .clr     (CLR),
      .adv     (adv),
      .vld_in  (stg_vld_in[g]),
      .dat_in  (stg_dat_in[g]),
      .vld_out (vld_pipe[g]),
      .dat_out (prod_pipe[g])
    );
  end

  assign bus.OUT_VALID = vld_pipe[num_stages-1];
  assign bus.PRODUCT   = prod_pipe[num_stages-1];
endmodule
